// File: rtl/ofdm_pkg.sv
// ----------------------------------------------------------------------------
// ofdm_pkg
// Shared OFDM/QPSK definitions for the TX frame mapper and the RX demapper.
//   - Default frame geometry (N_FFT, N_USED_HALF).
//   - I/Q sample width and the QPSK magnitude AMP (round(2^15/sqrt2)).
//   - Pilot bin indices (the lower pair; the upper pair mirrors them at
//     N_FFT-PILOT_HI and N_FFT-PILOT_LO).
//   - Bin-class and mapper FSM state enums.
//   - qpsk_map(): Gray map of a bit pair {b1,b0} onto a packed {I,Q} word.
// Optional feature macro: QPSK_PILOT_INSERT_EN (consumed by the classifier).
// ----------------------------------------------------------------------------
package ofdm_pkg;

    localparam int N_FFT_DEFAULT       = 64;
    localparam int N_USED_HALF_DEFAULT = 26;
    localparam int IQ_WIDTH            = 16;
    localparam int AMP                 = 23170;

    // Lower-half pilot indices; the upper-half pilots are N_FFT minus these.
    localparam int PILOT_LO = 7;
    localparam int PILOT_HI = 21;

    localparam logic signed [IQ_WIDTH-1:0] AMP_POS = IQ_WIDTH'(AMP);
    localparam logic signed [IQ_WIDTH-1:0] AMP_NEG = IQ_WIDTH'(-AMP);

    typedef enum logic [1:0] {
        BIN_NULL  = 2'd0,
        BIN_DATA  = 2'd1,
        BIN_PILOT = 2'd2
    } bin_class_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } map_state_t;

    // Gray mapping: a set bit selects the negative rail on its axis, so
    // adjacent constellation points differ in exactly one bit.
    function automatic logic [2*IQ_WIDTH-1:0] qpsk_map(input logic [1:0] bits);
        logic signed [IQ_WIDTH-1:0] i_val;
        logic signed [IQ_WIDTH-1:0] q_val;
        i_val = bits[1] ? AMP_NEG : AMP_POS;
        q_val = bits[0] ? AMP_NEG : AMP_POS;
        return {i_val, q_val};
    endfunction

endpackage

// File: rtl/subcarrier_classifier.sv
// ----------------------------------------------------------------------------
// subcarrier_classifier
// Combinational subcarrier index -> bin class (NULL / DATA / PILOT).
// Shared between the TX mapper and the RX demapper so both sides agree on
// the frame layout.
//   Used bins : k = 1..N_USED_HALF and N_FFT-N_USED_HALF..N_FFT-1.
//   Pilots    : k in {PILOT_LO, PILOT_HI, N_FFT-PILOT_HI, N_FFT-PILOT_LO},
//               only when QPSK_PILOT_INSERT_EN is defined; otherwise those
//               bins are ordinary DATA bins.
//   Null      : everything else, including DC (k=0) and the guard band.
// Ports:
//   k    in   log2(N_FFT)  subcarrier index
//   cls  out  2            bin class (ofdm_pkg::bin_class_t encoding)
// ----------------------------------------------------------------------------
module subcarrier_classifier
    import ofdm_pkg::*;
#(
    parameter int N_FFT       = N_FFT_DEFAULT,
    parameter int N_USED_HALF = N_USED_HALF_DEFAULT
) (
    input  logic [$clog2(N_FFT)-1:0] k,
    output logic [1:0]               cls
);

    // The layout is static, so it is elaborated into a constant table and
    // the index simply selects an entry.
    logic [1:0] class_table [N_FFT];

    genvar gi;
    generate
        for (gi = 0; gi < N_FFT; gi++) begin : g_bin
            localparam bit USED = ((gi >= 1) && (gi <= N_USED_HALF)) ||
                                  (gi >= N_FFT - N_USED_HALF);
`ifdef QPSK_PILOT_INSERT_EN
            localparam bit PILOT = (gi == PILOT_LO) || (gi == PILOT_HI) ||
                                   (gi == N_FFT - PILOT_HI) ||
                                   (gi == N_FFT - PILOT_LO);
`else
            localparam bit PILOT = 1'b0;
`endif
            assign class_table[gi] = !USED ? BIN_NULL :
                                     (PILOT ? BIN_PILOT : BIN_DATA);
        end
    endgenerate

    assign cls = class_table[k];

endmodule

// File: rtl/qpsk_frame_mapper.sv
// ----------------------------------------------------------------------------
// qpsk_frame_mapper
// Takes 2-bit words from the ROM bit-pair source, Gray-maps them to QPSK
// points and lays them onto one OFDM frame of N_FFT bins in index order,
// inserting DC/guard nulls (and pilots when QPSK_PILOT_INSERT_EN is
// defined). Output is a registered valid/ready stream to the IFFT.
// Ports:
//   clk        in   1            clock, rising edge
//   rst        in   1            synchronous active-low reset
//   en         in   1            global enable; low freezes all state
//   data_rom   in   2            bit pair {b1,b0}
//   valid_rom  in   1            data_rom valid
//   ready_in   out  1            upstream accept (only on DATA bins)
//   i_out      out  IQ_WIDTH     signed in-phase
//   q_out      out  IQ_WIDTH     signed quadrature
//   k_out      out  log2(N_FFT)  subcarrier index of the current output
//   sof_out    out  1            high with bin k=0
//   eof_out    out  1            high with bin k=N_FFT-1
//   valid_out  out  1            output valid
//   ready_out  in   1            downstream accept
// Optional feature macro: QPSK_PILOT_INSERT_EN.
// ----------------------------------------------------------------------------
module qpsk_frame_mapper
    import ofdm_pkg::*;
#(
    parameter int N_FFT       = N_FFT_DEFAULT,
    parameter int N_USED_HALF = N_USED_HALF_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 data_rom,
    input  logic                       valid_rom,
    output logic                       ready_in,
    output logic signed [IQ_WIDTH-1:0] i_out,
    output logic signed [IQ_WIDTH-1:0] q_out,
    output logic [$clog2(N_FFT)-1:0]   k_out,
    output logic                       sof_out,
    output logic                       eof_out,
    output logic                       valid_out,
    input  logic                       ready_out
);

    localparam int             KW     = $clog2(N_FFT);
    localparam logic [KW-1:0]  K_LAST = KW'(N_FFT - 1);

    map_state_t                 state_reg, state_next;
    logic [KW-1:0]              k_reg,     k_next;
    logic                       valid_reg, valid_next;
    logic signed [IQ_WIDTH-1:0] i_reg,     i_next;
    logic signed [IQ_WIDTH-1:0] q_reg,     q_next;
    logic [KW-1:0]              kout_reg,  kout_next;
    logic                       sof_reg,   sof_next;
    logic                       eof_reg,   eof_next;

    logic                       adv;
    logic [1:0]                 cls;
    logic [2*IQ_WIDTH-1:0]      mapped;

    subcarrier_classifier #(
        .N_FFT       (N_FFT),
        .N_USED_HALF (N_USED_HALF)
    ) u_classifier (
        .k   (k_reg),
        .cls (cls)
    );

    assign mapped = qpsk_map(data_rom);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
            valid_reg <= 1'b0;
            i_reg     <= '0;
            q_reg     <= '0;
            kout_reg  <= '0;
            sof_reg   <= 1'b0;
            eof_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            valid_reg <= valid_next;
            i_reg     <= i_next;
            q_reg     <= q_next;
            kout_reg  <= kout_next;
            sof_reg   <= sof_next;
            eof_reg   <= eof_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        valid_next = valid_reg;
        i_next     = i_reg;
        q_next     = q_reg;
        kout_next  = kout_reg;
        sof_next   = sof_reg;
        eof_next   = eof_reg;

        // The output register can take a new bin when it is empty or being
        // popped this cycle, so pop and load may coincide (no skid needed).
        adv      = en && (!valid_reg || ready_out);
        ready_in = adv && (state_reg == ST_RUN) && (cls == BIN_DATA);

        case (state_reg)
            ST_IDLE: begin
                // Let the last bin of the previous frame drain; a new frame
                // only starts once the source has data, but nothing is
                // consumed on this transition (k=0 is a null bin anyway).
                if (adv) begin
                    valid_next = 1'b0;
                end
                if (en && valid_rom) begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (adv) begin
                    if ((cls == BIN_DATA) && !valid_rom) begin
                        // Source starved on a data bin: emit a bubble and
                        // retry the same bin so no index is skipped.
                        valid_next = 1'b0;
                    end else begin
                        valid_next = 1'b1;
                        kout_next  = k_reg;
                        sof_next   = (k_reg == '0);
                        eof_next   = (k_reg == K_LAST);
                        if (cls == BIN_DATA) begin
                            i_next = mapped[2*IQ_WIDTH-1:IQ_WIDTH];
                            q_next = mapped[IQ_WIDTH-1:0];
                        end else if (cls == BIN_PILOT) begin
                            i_next = AMP_POS;
                            q_next = '0;
                        end else begin
                            i_next = '0;
                            q_next = '0;
                        end
                        if (k_reg == K_LAST) begin
                            k_next     = '0;
                            state_next = ST_IDLE;
                        end else begin
                            k_next = k_reg + 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign i_out     = i_reg;
    assign q_out     = q_reg;
    assign k_out     = kout_reg;
    assign sof_out   = sof_reg;
    assign eof_out   = eof_reg;
    assign valid_out = valid_reg;

endmodule
